io_handler_multi: RTL

// - Next-generation front-panel I/O block: debounces reset and mode buttons, keeps a wrapping mode index with
//   one-hot LED drive, and pulse-stretches N comm-activity inputs onto N LEDs. Sits between board pins and
//   the MITM core; debounced_rst feeds the top-level reset tree, mode_select feeds the core mode mux.

---
 rtl/io_handler_multi.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/io_handler_multi.sv
// io_handler_multi: front-panel I/O block.
// Debounces the reset and mode buttons, keeps a wrapping mode index with one-hot
// LED drive, and pulse-stretches NUM_COMM_CH activity strobes onto LEDs.
// Optional feature macro: IO_LONG_PRESS_EN moves the mode action to button release
// (short press = next mode, long press = previous mode).
module io_handler_multi #(
    parameter int SYS_FREQ_HZ          = 12_000_000,
    parameter int DEBOUNCE_DURATION_US = 1,
    parameter int BUTTONS_ACTIVE_LOW   = 1,
    parameter int NUM_MODES            = 4,
    parameter int MODE_WIDTH           = 2,
    parameter int NUM_COMM_CH          = 2,
    parameter int COMM_LED_HOLD_US     = 10,
    parameter int LONG_PRESS_US        = 5
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   rst_btn,
    input  logic                   mode_select_btn,
    input  logic [NUM_COMM_CH-1:0] comm_active,
    output logic                   debounced_rst,
    output logic [MODE_WIDTH-1:0]  mode_select,
    output logic [NUM_MODES-1:0]   mode_leds,
    output logic                   mode_changed,
    output logic [NUM_COMM_CH-1:0] comm_active_leds
);

    localparam int CYC_PER_US  = SYS_FREQ_HZ / 1_000_000;
    localparam int DB_CYCLES   = CYC_PER_US * DEBOUNCE_DURATION_US;
    localparam int HOLD_CYCLES = CYC_PER_US * COMM_LED_HOLD_US;
    localparam int DB_CNT_W    = $clog2(DB_CYCLES) + 1;
    localparam int HOLD_CNT_W  = $clog2(HOLD_CYCLES) + 1;

    localparam logic [DB_CNT_W-1:0]   DB_LAST   = DB_CNT_W'(DB_CYCLES - 1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES);
    localparam logic [MODE_WIDTH-1:0] MODE_MAX  = MODE_WIDTH'(NUM_MODES - 1);
    localparam logic [NUM_MODES-1:0]  LEDS_MODE0 = {{(NUM_MODES-1){1'b0}}, 1'b1};

    // Button slot indices inside the shared debounce vectors.
    localparam int BTN_RST  = 0;
    localparam int BTN_MODE = 1;

    // Reject configurations the counters and mode index cannot represent.
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("io_handler_multi: debounce time must be at least one clock cycle");
    end
    if (NUM_MODES < 2) begin : g_bad_modes_min
        $error("io_handler_multi: NUM_MODES must be at least 2");
    end
    if (NUM_MODES > (2 ** MODE_WIDTH)) begin : g_bad_modes_width
        $error("io_handler_multi: NUM_MODES does not fit in MODE_WIDTH bits");
    end

`ifdef IO_LONG_PRESS_EN
    localparam int LONG_CYCLES = CYC_PER_US * LONG_PRESS_US;
    localparam int LONG_CNT_W  = $clog2(LONG_CYCLES) + 1;
    localparam logic [LONG_CNT_W-1:0] LONG_SAT = LONG_CNT_W'(LONG_CYCLES);
`else
    if (LONG_PRESS_US < 0) begin : g_bad_long
        $error("io_handler_multi: LONG_PRESS_US must not be negative");
    end
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } mode_state_t;

    // Binary mode index to one-hot LED pattern.
    function automatic logic [NUM_MODES-1:0] mode_onehot(input logic [MODE_WIDTH-1:0] m);
        logic [NUM_MODES-1:0] r;
        for (int i = 0; i < NUM_MODES; i++) begin
            r[i] = (m == MODE_WIDTH'(i));
        end
        return r;
    endfunction

    // Next mode with wrap from the last mode back to 0.
    function automatic logic [MODE_WIDTH-1:0] mode_inc(input logic [MODE_WIDTH-1:0] m);
        if (m >= MODE_MAX) begin
            return {MODE_WIDTH{1'b0}};
        end else begin
            return m + 1'b1;
        end
    endfunction

`ifdef IO_LONG_PRESS_EN
    // Previous mode with wrap from 0 to the last mode.
    function automatic logic [MODE_WIDTH-1:0] mode_dec(input logic [MODE_WIDTH-1:0] m);
        if (m == {MODE_WIDTH{1'b0}}) begin
            return MODE_MAX;
        end else begin
            return m - 1'b1;
        end
    endfunction
`endif

    logic [1:0]            btn_raw_s;
    logic [1:0]            btn_norm_s;
    logic [1:0]            sync1_r;
    logic [1:0]            sync2_r;
    logic [1:0]            stable_r;
    logic [DB_CNT_W-1:0]   db_cnt_r [2];
    logic                  debounced_rst_r;

    mode_state_t           state_r;
    mode_state_t           state_s;
    logic [MODE_WIDTH-1:0] mode_select_r;
    logic [MODE_WIDTH-1:0] mode_next_s;
    logic [NUM_MODES-1:0]  mode_leds_r;
    logic                  mode_changed_r;
    logic                  changed_next_s;
    logic                  mode_stable_s;

    logic [HOLD_CNT_W-1:0]  hold_cnt_r [NUM_COMM_CH];
    logic [NUM_COMM_CH-1:0] comm_leds_r;

`ifdef IO_LONG_PRESS_EN
    logic [LONG_CNT_W-1:0] long_cnt_r;
`endif

    // Normalise both buttons so that 1 always means pressed.
    assign btn_raw_s  = {mode_select_btn, rst_btn};
    assign btn_norm_s = (BUTTONS_ACTIVE_LOW != 0) ? ~btn_raw_s : btn_raw_s;
    assign mode_stable_s = stable_r[BTN_MODE];

    // Two-flop synchroniser and debounce counter for each button.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1_r  <= 2'b00;
            sync2_r  <= 2'b00;
            stable_r <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                db_cnt_r[b] <= {DB_CNT_W{1'b0}};
            end
        end else begin
            sync1_r <= btn_norm_s;
            sync2_r <= sync1_r;
            for (int b = 0; b < 2; b++) begin
                if (sync2_r[b] != stable_r[b]) begin
                    if (db_cnt_r[b] == DB_LAST) begin
                        stable_r[b] <= ~stable_r[b];
                        db_cnt_r[b] <= {DB_CNT_W{1'b0}};
                    end else begin
                        db_cnt_r[b] <= db_cnt_r[b] + 1'b1;
                    end
                end else begin
                    db_cnt_r[b] <= {DB_CNT_W{1'b0}};
                end
            end
        end
    end

    // Registered copy of the debounced reset button for the reset tree.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            debounced_rst_r <= 1'b0;
        end else begin
            debounced_rst_r <= stable_r[BTN_RST];
        end
    end

    // Mode FSM next-state and mode update decisions.
    always_comb begin
        state_s        = state_r;
        mode_next_s    = mode_select_r;
        changed_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mode_stable_s) begin
                    state_s = ST_HELD;
`ifndef IO_LONG_PRESS_EN
                    mode_next_s    = mode_inc(mode_select_r);
                    changed_next_s = 1'b1;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (!mode_stable_s) begin
                    state_s = ST_IDLE;
`ifdef IO_LONG_PRESS_EN
                    if (long_cnt_r < LONG_SAT) begin
                        mode_next_s = mode_inc(mode_select_r);
                    end else begin
                        mode_next_s = mode_dec(mode_select_r);
                    end
                    changed_next_s = 1'b1;
`endif
                end else begin
                    state_s = ST_HELD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Mode FSM state plus registered mode index, LEDs and change pulse.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            mode_select_r  <= {MODE_WIDTH{1'b0}};
            mode_leds_r    <= LEDS_MODE0;
            mode_changed_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            mode_select_r  <= mode_next_s;
            mode_leds_r    <= mode_onehot(mode_next_s);
            mode_changed_r <= changed_next_s;
        end
    end

`ifdef IO_LONG_PRESS_EN
    // Hold-time counter: cleared while released, saturates at the long-press threshold.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            long_cnt_r <= {LONG_CNT_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            long_cnt_r <= {LONG_CNT_W{1'b0}};
        end else if (mode_stable_s && (long_cnt_r < LONG_SAT)) begin
            long_cnt_r <= long_cnt_r + 1'b1;
        end else begin
            long_cnt_r <= long_cnt_r;
        end
    end
`endif

    // Per-channel activity stretcher; a new strobe reloads the full hold time.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            comm_leds_r <= {NUM_COMM_CH{1'b0}};
            for (int i = 0; i < NUM_COMM_CH; i++) begin
                hold_cnt_r[i] <= {HOLD_CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_COMM_CH; i++) begin
                if (comm_active[i]) begin
                    hold_cnt_r[i]  <= HOLD_LOAD;
                    comm_leds_r[i] <= 1'b1;
                end else if (hold_cnt_r[i] != {HOLD_CNT_W{1'b0}}) begin
                    hold_cnt_r[i]  <= hold_cnt_r[i] - 1'b1;
                    comm_leds_r[i] <= 1'b1;
                end else begin
                    hold_cnt_r[i]  <= hold_cnt_r[i];
                    comm_leds_r[i] <= 1'b0;
                end
            end
        end
    end

    assign debounced_rst    = debounced_rst_r;
    assign mode_select      = mode_select_r;
    assign mode_leds        = mode_leds_r;
    assign mode_changed     = mode_changed_r;
    assign comm_active_leds = comm_leds_r;

endmodule
